// File: rtl/nco_freq_ctrl.sv
// Frequency controller for the NCO/CORDIC downconverter: host tuning port with priority over
// a linear sweeper, plus CORDIC latency tracking so downstream logic knows when samples are valid.
module nco_freq_ctrl #(
   parameter int WF      = 32,
   parameter int LATENCY = 20,
   parameter int DWELL_W = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               host_req,
   input  logic [WF-1:0]      host_freq,
   output logic               host_ack,
   input  logic               sweep_en,
   input  logic [WF-1:0]      sweep_start,
   input  logic [WF-1:0]      sweep_stop,
   input  logic [WF-1:0]      sweep_step,
   input  logic [DWELL_W-1:0] sweep_dwell,
   output logic [WF-1:0]      frequency,
   output logic               busy,
   output logic               settled,
   output logic               sweep_done
);

   localparam logic [1:0] S_RESET_SETTLE = 2'd0;
   localparam logic [1:0] S_IDLE         = 2'd1;
   localparam logic [1:0] S_SETTLE       = 2'd2;
   localparam logic [1:0] S_DWELL        = 2'd3;

   // One counter serves both the latency wait and the dwell wait.
   localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int CNT_W = (LAT_W > DWELL_W) ? LAT_W : DWELL_W;
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WF-1:0]    freq_q, freq_d;
   logic             ack_q, ack_d;
   logic             done_q, done_d;
   logic             armed_q, armed_d;
   logic             active_q, active_d;
   logic             en_q;

   logic             host_load;
   logic             en_rise;
   logic [CNT_W-1:0] dwell_load;
   logic signed [WF:0] next_freq;
   logic signed [WF:0] stop_x;
   logic             sweep_finish;

   assign host_load = host_req & ~ack_q;
   assign en_rise   = sweep_en & ~en_q;
   assign dwell_load = (sweep_dwell == '0) ? '0 : CNT_W'(sweep_dwell - 1'b1);

   // The bound is compared one bit wider so a step past the end of the range cannot wrap.
   assign next_freq = $signed({freq_q[WF-1], freq_q}) + $signed({sweep_step[WF-1], sweep_step});
   assign stop_x    = $signed({sweep_stop[WF-1], sweep_stop});
   assign sweep_finish = (sweep_step == '0)
                      || (!sweep_step[WF-1] && (next_freq > stop_x))
                      || ( sweep_step[WF-1] && (next_freq < stop_x));

   always_comb begin
      // NOTE: every next-state signal gets a default first so no latch is inferred.
      state_d  = state_q;
      cnt_d    = cnt_q;
      freq_d   = freq_q;
      ack_d    = 1'b0;
      done_d   = 1'b0;
      armed_d  = armed_q | en_rise;
      active_d = active_q;

      if (host_load) begin
         freq_d   = host_freq;
         ack_d    = 1'b1;
         cnt_d    = LAT_LOAD;
         state_d  = S_SETTLE;
         active_d = 1'b0;
         armed_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (armed_q) begin
                  freq_d   = sweep_start;
                  active_d = 1'b1;
                  armed_d  = 1'b0;
                  cnt_d    = LAT_LOAD;
                  state_d  = S_SETTLE;
               end
            end
            S_DWELL: begin
               if (!sweep_en) begin
                  active_d = 1'b0;
                  state_d  = S_IDLE;
               end else if (cnt_q == '0) begin
                  if (sweep_finish) begin
                     done_d   = 1'b1;
                     active_d = 1'b0;
                     state_d  = S_IDLE;
                  end else begin
                     freq_d  = next_freq[WF-1:0];
                     cnt_d   = LAT_LOAD;
                     state_d = S_SETTLE;
                  end
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: begin
               // RESET_SETTLE and SETTLE: an abort only clears active, the count still runs out.
               active_d = active_q & sweep_en;
               if (cnt_q == '0) begin
                  if (active_q && sweep_en) begin
                     cnt_d   = dwell_load;
                     state_d = S_DWELL;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_RESET_SETTLE;
         cnt_q    <= LAT_LOAD;
         freq_q   <= '0;
         ack_q    <= 1'b0;
         done_q   <= 1'b0;
         armed_q  <= 1'b0;
         active_q <= 1'b0;
         en_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         freq_q   <= freq_d;
         ack_q    <= ack_d;
         done_q   <= done_d;
         armed_q  <= armed_d;
         active_q <= active_d;
         en_q     <= sweep_en;
      end
   end

   assign frequency  = freq_q;
   assign host_ack   = ack_q;
   assign sweep_done = done_q;
   assign busy       = (state_q != S_IDLE);
   assign settled    = (state_q == S_IDLE) || (state_q == S_DWELL);

endmodule

// File: tb/tb_nco_freq_ctrl.sv
// Scoreboard bench for nco_freq_ctrl: expected loads and sweep_done cycles are queued when
// stimulus is applied and matched by a monitor as the DUT produces them.
module tb_nco_freq_ctrl;

   localparam int WF      = 32;
   localparam int LATENCY = 20;
   localparam int DWELL_W = 16;

   typedef struct {
      logic [WF-1:0] freq;
      int            cyc;
   } exp_t;

   logic               clock = 1'b0;
   logic               reset;
   logic               host_req;
   logic [WF-1:0]      host_freq;
   logic               host_ack;
   logic               sweep_en;
   logic [WF-1:0]      sweep_start;
   logic [WF-1:0]      sweep_stop;
   logic [WF-1:0]      sweep_step;
   logic [DWELL_W-1:0] sweep_dwell;
   logic [WF-1:0]      frequency;
   logic               busy;
   logic               settled;
   logic               sweep_done;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   bit   mon_en = 0;
   logic [WF-1:0] prev_freq;
   logic prev_settled;
   int   last_load = 0;
   exp_t exp_q[$];
   int   done_q[$];

   nco_freq_ctrl #(.WF(WF), .LATENCY(LATENCY), .DWELL_W(DWELL_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .host_req    (host_req),
      .host_freq   (host_freq),
      .host_ack    (host_ack),
      .sweep_en    (sweep_en),
      .sweep_start (sweep_start),
      .sweep_stop  (sweep_stop),
      .sweep_step  (sweep_step),
      .sweep_dwell (sweep_dwell),
      .frequency   (frequency),
      .busy        (busy),
      .settled     (settled),
      .sweep_done  (sweep_done)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) tick();
   endtask

   task automatic wait_idle(input int max_cyc);
      int n = 0;
      while (busy && n < max_cyc) begin
         tick();
         n++;
      end
      check("idle_timeout", {63'd0, busy}, 64'd0);
   endtask

   task automatic host_load(input logic [WF-1:0] val);
      exp_t e;
      e.freq = val;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
      host_freq = val;
      host_req  = 1'b1;
      tick();
      check("ack_high", {63'd0, host_ack}, 64'd1);
      host_req = 1'b0;
      tick();
      check("ack_low", {63'd0, host_ack}, 64'd0);
   endtask

   // Re-arms via a fresh sweep_en rising edge; optionally queues the whole expected schedule.
   task automatic arm_sweep(input int start, input int stop, input int step, input int dwell,
                            input bit sched, output int k);
      exp_t   e;
      longint v, nx;
      int     t, p;
      sweep_en = 1'b0;
      tick();
      sweep_start = WF'(start);
      sweep_stop  = WF'(stop);
      sweep_step  = WF'(step);
      sweep_dwell = DWELL_W'(dwell);
      sweep_en    = 1'b1;
      k = cyc;
      if (sched) begin
         p = LATENCY + ((dwell == 0) ? 1 : dwell);
         v = start;
         t = k + 2;
         e.freq = WF'(v);
         e.cyc  = t;
         exp_q.push_back(e);
         forever begin
            nx = v + step;
            if (step == 0 || (step > 0 && nx > stop) || (step < 0 && nx < stop)) begin
               done_q.push_back(t + p);
               break;
            end
            v = nx;
            t = t + p;
            e.freq = WF'(v);
            e.cyc  = t;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic push_load(input logic [WF-1:0] val, input int at);
      exp_t e;
      e.freq = val;
      e.cyc  = at;
      exp_q.push_back(e);
   endtask

   always @(negedge clock) begin
      if (mon_en) begin
         if (frequency !== prev_freq) begin
            if (exp_q.size() == 0) begin
               check("unexpected_load", {32'd0, frequency}, {32'd0, prev_freq});
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("load_freq", {32'd0, frequency}, {32'd0, e.freq});
               check("load_cycle", 64'(cyc), 64'(e.cyc));
            end
            last_load = cyc;
            prev_freq = frequency;
         end
         if (settled && !prev_settled) check("settle_len", 64'(cyc - last_load), 64'(LATENCY));
         prev_settled = settled;
         if (sweep_done) begin
            if (done_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
            else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k, n;
      reset       = 1'b1;
      host_req    = 1'b0;
      host_freq   = '0;
      sweep_en    = 1'b1;
      sweep_start = '0;
      sweep_stop  = '0;
      sweep_step  = '0;
      sweep_dwell = '0;

      // Reset with sweep_en held high: settle for LATENCY cycles, no sweep.
      repeat (3) tick();
      reset = 1'b0;
      check("rst_freq", {32'd0, frequency}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd1);
      check("rst_settled", {63'd0, settled}, 64'd0);
      n = 0;
      while (!settled && n < 100) begin
         tick();
         n++;
      end
      check("rst_settle_len", 64'(n), 64'(LATENCY));
      repeat (5) tick();
      check("rst_no_sweep", {63'd0, busy}, 64'd0);
      check("rst_freq_idle", {32'd0, frequency}, 64'd0);
      prev_freq    = frequency;
      prev_settled = settled;
      mon_en       = 1'b1;

      // Host load from IDLE.
      host_load(32'h0CCC_CCCD);
      wait_idle(100);
      check("host_freq_hold", {32'd0, frequency}, 64'h0CCC_CCCD);

      // Upward sweep, dwell 4.
      arm_sweep(1000, 1300, 100, 4, 1'b1, k);
      tick();
      tick();
      wait_idle(400);
      repeat (5) tick();
      check("up_final", {32'd0, frequency}, 64'd1300);

      // Downward sweep, dwell 0 treated as 1.
      arm_sweep(0, -250, -100, 0, 1'b1, k);
      tick();
      tick();
      wait_idle(400);
      repeat (5) tick();
      check("down_final", {32'd0, frequency}, {32'd0, 32'(-200)});

      // Zero step: one load, then done.
      arm_sweep(500, 0, 0, 3, 1'b1, k);
      tick();
      tick();
      wait_idle(200);
      check("step0_final", {32'd0, frequency}, 64'd500);

      // Host load in the middle of the 1100 dwell aborts the sweep.
      arm_sweep(1000, 1300, 100, 4, 1'b0, k);
      push_load(32'd1000, k + 2);
      push_load(32'd1100, k + 2 + 24);
      wait_cyc(k + 47);
      host_load(32'h1234_5678);
      wait_idle(100);
      repeat (60) tick();
      check("abort_freq", {32'd0, frequency}, 64'h1234_5678);
      check("abort_idle", {63'd0, busy}, 64'd0);

      // Re-arming restarts the full sweep from sweep_start.
      arm_sweep(1000, 1300, 100, 4, 1'b1, k);
      tick();
      tick();
      wait_idle(400);

      // Host request in the same cycle an armed sweep would start: host wins.
      arm_sweep(1000, 1300, 100, 4, 1'b0, k);
      tick();
      host_load(32'h0BAD_CAFE);
      wait_idle(100);
      repeat (30) tick();
      check("collide_freq", {32'd0, frequency}, 64'h0BAD_CAFE);
      check("collide_idle", {63'd0, busy}, 64'd0);

      // sweep_en dropped mid-SETTLE: latency count completes, then IDLE with no done.
      arm_sweep(1000, 1300, 100, 4, 1'b0, k);
      push_load(32'd1000, k + 2);
      wait_cyc(k + 10);
      sweep_en = 1'b0;
      wait_cyc(k + 21);
      check("drop_still_busy", {63'd0, busy}, 64'd1);
      tick();
      check("drop_idle", {63'd0, busy}, 64'd0);
      check("drop_freq", {32'd0, frequency}, 64'd1000);
      repeat (40) tick();

      check("loads_pending", 64'(exp_q.size()), 64'd0);
      check("done_pending", 64'(done_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
